// File: rtl/btn_pkg.sv
// Shared types for the push-button front end: channel state encoding and
// the counter-width helper used to size the debounce/hold/repeat counters.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_t;

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold timer and
// optional auto-repeat (enabled by defining BTN_REPEAT_EN).
//
// state      | meaning
// IDLE       | released and stable
// PRESS_WAIT | synced pin low, counting stable cycles before accepting press
// HELD       | press accepted, level high, hold timer running
// REL_WAIT   | synced pin high while held, counting stable cycles before release
module btn_chan
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES    = 270000,
  parameter int LONG_CYCLES   = 27000000,
  parameter int REPEAT_CYCLES = 5400000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press_p,
  output logic release_p,
  output logic long_p,
  output logic repeat_p
);

  localparam int DW = cnt_w(DEB_CYCLES);
  localparam int HW = cnt_w(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);

  logic [1:0]    sync;
  logic          s;
  btn_state_t    state;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;

  assign s = sync[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync      <= 2'b11;
      state     <= IDLE;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      level     <= 1'b0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
    end else begin
      sync      <= {sync[0], btn_n};
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (!s) begin
            state   <= PRESS_WAIT;
            deb_cnt <= DW'(1);
          end
        end
        PRESS_WAIT: begin
          if (s) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= HELD;
            deb_cnt <= '0;
            level   <= 1'b1;
            press_p <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        HELD: begin
          // hold timer keeps running through release bounces, saturating at the long-press mark
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HW'(1);
            long_p   <= (hold_cnt == HOLD_PRE);
          end
          if (s) begin
            state   <= REL_WAIT;
            deb_cnt <= DW'(1);
          end
        end
        REL_WAIT: begin
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HW'(1);
            long_p   <= (hold_cnt == HOLD_PRE);
          end
          if (!s) begin
            state   <= HELD;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            level     <= 1'b0;
            release_p <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RW = cnt_w(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;

  // repeat timer only runs once the hold timer has saturated, i.e. after long_p
  always_ff @(posedge clk) begin
    if (!rst) begin
      rep_cnt  <= '0;
      repeat_p <= 1'b0;
    end else begin
      repeat_p <= 1'b0;
      if ((state == HELD || state == REL_WAIT) && hold_cnt == HOLD_MAX) begin
        if (rep_cnt == REP_LAST) begin
          rep_cnt  <= '0;
          repeat_p <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + RW'(1);
        end
      end else begin
        rep_cnt <= '0;
      end
    end
  end
`else
  // constant 0; the comparison only keeps the repeat period parameter referenced
  assign repeat_p = (REPEAT_CYCLES < 0);
`endif

endmodule

// File: rtl/btn_debounce.sv
// Push-button front end: NBTN independent debounced channels producing level
// and press/release/long/repeat pulses (repeat only with BTN_REPEAT_EN).
module btn_debounce
  import btn_pkg::*;
#(
  parameter int NBTN          = 2,
  parameter int DEB_CYCLES    = 270000,
  parameter int LONG_CYCLES   = 27000000,
  parameter int REPEAT_CYCLES = 5400000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_n,
  output logic [NBTN-1:0] level,
  output logic [NBTN-1:0] press_p,
  output logic [NBTN-1:0] release_p,
  output logic [NBTN-1:0] long_p,
  output logic [NBTN-1:0] repeat_p
);

  for (genvar g = 0; g < NBTN; g++) begin : g_chan
    btn_chan #(
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .btn_n    (btn_n[g]),
      .level    (level[g]),
      .press_p  (press_p[g]),
      .release_p(release_p[g]),
      .long_p   (long_p[g]),
      .repeat_p (repeat_p[g])
    );
  end

endmodule
